// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: PID codes, scheduler states and the handshake PID sanitiser
package usb_tx_pkg;
  localparam logic [1:0] PID_ACK = 2'b00;
  localparam logic [1:0] PID_NAK = 2'b01;
  localparam logic [1:0] PID_STALL = 2'b10;
  localparam logic [1:0] PID_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, HS_ISSUE, HS_WAIT, DATA_ISSUE, DATA_SEND, GAP} state_t;
  function automatic logic [1:0] hs_pid_map(input logic [1:0] p);
    return (p == PID_ACK || p == PID_NAK) ? p : PID_STALL;
  endfunction
endpackage

// File: rtl/tx_sched_counter.sv
// tx_sched_counter: clearable saturating up-counter flagging when it reaches a limit
module tx_sched_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= clr ? '0 : (&cnt ? cnt : cnt + 1'b1);
  assign hit = cnt >= lim;
endmodule

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates handshake vs data packets onto the USB transmitter,
// feeds payload bytes from a show-ahead FIFO, enforces inter-packet gap and timeout
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int LEN_W          = 7,
  parameter int IPG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hs_req,
  input  logic [1:0]       hs_pid,
  input  logic             data_req,
  input  logic [LEN_W-1:0] data_len,
  input  logic [7:0]       fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             byte_pull,
  input  logic             ack_done,
  input  logic             tx_complete,
  output logic             tx_ena,
  output logic             ack_prep,
  output logic [1:0]       pid,
  output logic [7:0]       parallel_in,
  output logic             hs_done,
  output logic             data_done,
  output logic             err_timeout,
  output logic             err_underrun,
  output logic             busy
);
  state_t state, next;
  logic [LEN_W-1:0] bytes_left;
  logic [CNT_W-1:0] lim;
  logic hit, load;
  // the counter restarts on every state change, so it measures time spent in the current state
  assign lim = state == GAP ? CNT_W'(IPG_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1);
  tx_sched_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (next != state),
    .lim  (lim),
    .hit  (hit)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:       next = hs_req ? HS_ISSUE : (data_req ? DATA_ISSUE : IDLE);
      HS_ISSUE:   next = HS_WAIT;
      HS_WAIT:    next = (ack_done || hit) ? GAP : HS_WAIT;
      DATA_ISSUE: next = DATA_SEND;
      DATA_SEND:  next = (tx_complete || hit) ? GAP : DATA_SEND;
      GAP:        next = hit ? IDLE : GAP;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    ack_prep = state == HS_ISSUE;
    tx_ena   = state == DATA_ISSUE;
    busy     = state != IDLE;
    load     = bytes_left != '0 &&
               (tx_ena || (state == DATA_SEND && byte_pull && !tx_complete && !hit));
    fifo_rd  = load && !fifo_empty;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      pid          <= PID_DATA;
      parallel_in  <= 8'h00;
      bytes_left   <= '0;
      hs_done      <= 1'b0;
      data_done    <= 1'b0;
      err_timeout  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      hs_done      <= state == HS_WAIT && ack_done;
      data_done    <= state == DATA_SEND && tx_complete;
      err_timeout  <= hit && ((state == HS_WAIT && !ack_done) || (state == DATA_SEND && !tx_complete));
      err_underrun <= (load && fifo_empty) || (state == DATA_SEND && tx_complete && bytes_left != '0);
      if (state == IDLE && hs_req) pid <= hs_pid_map(hs_pid);
      else if (state == IDLE && data_req) pid <= PID_DATA;
      if (state == IDLE && !hs_req && data_req) bytes_left <= data_len;
      else if (load) bytes_left <= bytes_left - 1'b1;
      if (load) parallel_in <= fifo_empty ? 8'h00 : fifo_rdata;
    end
endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Sequences the USB transmit path and shares it between two requesters: the handshake responder (ACK/NAK/STALL) and the data-packet source (payload held in an external show-ahead byte FIFO). Drives the transmitter's start strobes (tx_ena, ack_prep), pid and parallel_in, and feeds payload bytes on demand. Enforces an inter-packet gap and a completion timeout. Sits between the protocol/endpoint logic and usb_transmitter.

Parameters:
LEN_W, 7, width of data_len; maximum payload is 2^LEN_W-1 bytes.
IPG_CYCLES, 16, idle clocks enforced after every transaction, including aborted ones; must be >= 1.
TIMEOUT_CYCLES, 4096, clocks allowed between a start strobe and its completion before abort.
CNT_W, 13, width of the shared gap/timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
hs_req  in  1  handshake request; level, held until hs_done
hs_pid  in  2  00 ACK, 01 NAK, 10 STALL; 11 is illegal and is sent as STALL
data_req  in  1  data-packet request; level, held until data_done
data_len  in  LEN_W  payload byte count; 0 is a legal zero-length packet
fifo_rdata  in  8  show-ahead FIFO head byte
fifo_empty  in  1  FIFO empty
fifo_rd  out  1  pop strobe, one cycle per byte
byte_pull  in  1  transmitter consumed parallel_in and wants the next byte
ack_done  in  1  transmitter handshake-complete pulse
tx_complete  in  1  transmitter data-packet-complete pulse
tx_ena  out  1  data-packet start, one-cycle pulse
ack_prep  out  1  handshake start, one-cycle pulse
pid  out  2  registered; held stable for the whole transaction
parallel_in  out  8  registered payload byte
hs_done  out  1  one-cycle pulse
data_done  out  1  one-cycle pulse
err_timeout  out  1  one-cycle pulse
err_underrun  out  1  one-cycle pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, n_rst=0): state IDLE. All strobes, done and err outputs are 0. pid=2'b11, parallel_in=8'h00, busy=0, counters cleared. Reset mid-transaction abandons the transaction silently with no done or err pulse.
- States: IDLE, HS_ISSUE, HS_WAIT, DATA_ISSUE, DATA_SEND, GAP.
- IDLE
  - Requests are sampled only in IDLE; a request arriving in any other state waits.
  - hs_req has strict priority over data_req when both are high.
  - hs_req accepted: latch pid <= hs_pid (11 mapped to 10) and go to HS_ISSUE.
  - Else data_req accepted: latch pid <= 2'b11 and bytes_left <= data_len, then go to DATA_ISSUE.
- HS_ISSUE (1 cycle): ack_prep=1, clear counter, go to HS_WAIT.
- HS_WAIT
  - On ack_done: hs_done=1 on the same registered edge, then go to GAP.
  - If the counter reaches TIMEOUT_CYCLES first: err_timeout=1, no hs_done, go to GAP.
- DATA_ISSUE (1 cycle): tx_ena=1, clear counter.
  - If bytes_left>0: parallel_in <= fifo_rdata, fifo_rd=1, bytes_left decrements.
  - Go to DATA_SEND.
- DATA_SEND
  - On byte_pull with bytes_left>0: load the next byte, pop, decrement.
  - byte_pull with bytes_left=0 is ignored.
  - Underrun: a load is due while fifo_empty=1. Then err_underrun=1, parallel_in <= 8'h00, no pop, bytes_left still decrements, and the packet continues.
  - On tx_complete: data_done=1, go to GAP. If bytes_left≠0 at that point, err_underrun=1 as well.
  - Timeout as in HS_WAIT: err_timeout=1, no data_done.
  - If byte_pull and tx_complete coincide: complete wins and the pull is ignored.
- GAP: count IPG_CYCLES clocks, then go to IDLE. A request pending at the end of GAP is accepted in the IDLE cycle that follows, so the minimum spacing between start strobes is IPG_CYCLES+3 clocks.
- Requesters drop their req the cycle after the matching done/err pulse. The scheduler does not re-accept until it returns to IDLE.
- ack_done/tx_complete arriving in an unexpected state are ignored.
- One shared counter serves both the gap and the timeout; it saturates and never wraps.

Decomposition:
- Shared package usb_tx_pkg:
  - PID constants PID_ACK=2'b00, PID_NAK=2'b01, PID_STALL=2'b10, PID_DATA=2'b11.
  - typedef enum state_t.
- Sub-module tx_sched_counter holds the clearable, saturating up-counter with a compare-to-limit output, shared by GAP and the WAIT states.

Test Plan:
- hs_req=1, hs_pid=01 → ack_prep pulses 1 cycle after accept, pid=01 held. ack_done 10 cycles later → hs_done next edge. busy drops IPG_CYCLES (16) clocks later.
- data_req, data_len=3, FIFO {A1,B2,C3} → tx_ena with parallel_in=A1, then B2 and C3 on two byte_pulls. Exactly 3 fifo_rd. Fourth byte_pull ignored. tx_complete → data_done, no err.
- hs_req and data_req raised on the same cycle → handshake served first. data_req served after the gap: tx_ena exactly IPG_CYCLES+3 clocks after ack_prep when ack_done returns the cycle after ack_prep.
- data_len=2, FIFO holds 1 byte → second byte_pull gives err_underrun and parallel_in=00, with no second fifo_rd.
- ack_done withheld → err_timeout at 4096 clocks, no hs_done, IDLE after the gap.
- n_rst pulsed during DATA_SEND → outputs return to reset values immediately. A new data_len=0 request afterwards gives tx_ena with zero fifo_rd.
